pmod_switch_reader: RTL
=======================

// Module: pmod_switch_reader
// PURPOSE
//  Input side of the PMOD switch/LED pair: reads 8 raw active-low switches on a PMOD
//  port, synchronises and debounces each bit, presents a clean active-high switch
//  vector, and emits change events to a consumer over a valid/ready handshake.
//  Sits between the PMOD input pins and any logic that acts on switch changes.
// PARAMETERS
//  NUM_SW           8      number of switch inputs
//  DEBOUNCE_CYCLES  12000  consecutive stable cycles needed to accept a change (1 ms at 12 MHz); min 2
//  CNT_W            $clog2(DEBOUNCE_CYCLES)  debounce counter width (derived, not overridden)
// PORTS
//  CLK              in   1       system clock
//  RST_N            in   1       asynchronous active-low reset
//  SW_N             in   NUM_SW  raw switch pins, active-low, asynchronous to CLK
//  o_switches       out  NUM_SW  debounced switch state, active-high (1 = switch on)
//  o_event_valid    out  1       change event pending
//  i_event_ready    in   1       consumer accepts event when high with o_event_valid
//  o_event_data     out  NUM_SW  o_switches snapshot at the most recent merged change
//  o_event_changed  out  NUM_SW  mask of bits that changed since last accepted event
//  o_event_overflow out  1       (SWITCH_EVENT_OVERFLOW_EN only) sticky, see CONFIGURATION
// BEHAVIOUR
//  - Reset (async assert on RST_N low, sync deassert by system): sync flops = 1 (released),
//    debounce counters = 0, o_switches = 0, o_event_valid = 0, o_event_data = 0,
//    o_event_changed = 0, o_event_overflow = 0. Reset mid-debounce discards progress.
//  - Sync: 2-flop synchroniser per bit on SW_N; inverted after sync to active-high.
//  - Debounce per bit: if synced != stable, counter++; when counter == DEBOUNCE_CYCLES-1
//    and mismatch still present, stable <= synced, counter <= 0. If synced == stable,
//    counter <= 0 (any bounce restarts). Counter never wraps.
//  - Latency: raw edge held steady -> o_switches updates exactly DEBOUNCE_CYCLES+2 CLKs later.
//    Glitches shorter than DEBOUNCE_CYCLES never reach o_switches.
//  - Event FSM, 2 states: IDLE (valid=0), PENDING (valid=1).
//    change = stable_next ^ stable (any bit nonzero).
//    IDLE & change -> PENDING; data <= stable_next; changed <= change.
//    PENDING & ready & !change -> IDLE; changed <= 0; data held.
//    PENDING & ready & change -> stay PENDING; data <= stable_next; changed <= change (fresh).
//    PENDING & !ready & change -> merge: data <= stable_next; changed <= changed | change.
//    PENDING & !ready & !change -> hold all outputs stable (AXI-style, no retraction).
//  - Bit toggling twice while pending: changed bit stays 1, data shows final value.
//  - o_event_valid, o_event_data, o_event_changed asserted on same edge as o_switches update.
// CONFIGURATION
//  SWITCH_EVENT_OVERFLOW_EN defined: port o_event_overflow present; set to 1 on any merge
//   (PENDING & !ready & change); cleared only when event accepted (valid & ready) or reset.
//   Overflow refers to the event being accepted that cycle; a fresh load on accept clears it.
//  Not defined: port absent; merge behaviour identical, no indication.
// STRUCTURE
//  - Shared include pmod_defs.vh: PMOD_NUM_PINS = 8, SW_ACTIVE_LEVEL = 0, LED_ACTIVE_LEVEL = 0,
//    DEBOUNCE_1MS_12MHZ = 12000; shared with the LED writer side.
//  - Sub-module switch_debounce (one bit: synchroniser + counter + stable flop, params
//    DEBOUNCE_CYCLES); instantiated NUM_SW times via generate. Event FSM in top.
// TESTING (bench uses DEBOUNCE_CYCLES = 4, so latency = 6 CLKs)
//  1. Reset: hold RST_N=0, SW_N=8'h00 -> all outputs 0, valid 0; release -> after 6 CLKs
//     o_switches=8'hFF, valid=1, data=8'hFF, changed=8'hFF.
//  2. Debounce: SW_N bit0 low for 3 CLKs then high -> o_switches, valid unchanged;
//     low for 10 CLKs -> o_switches[0]=1 exactly 6 CLKs after edge, changed=8'h01.
//  3. Handshake: valid=1, ready=0 for 20 CLKs -> outputs stable; ready=1 one CLK -> valid=0 next.
//  4. Merge: event bit0 pending, ready=0; bit3 debounces -> data=8'h09, changed=8'h09,
//     overflow=1 (macro on); bit0 released -> data=8'h08, changed=8'h09.
//  5. Accept+change same CLK: ready=1 on edge bit5 updates -> valid stays 1, changed=8'h20,
//     overflow=0.
//  6. Reset mid-debounce: bit2 low 3 CLKs, pulse RST_N low -> counters cleared; no event until
//     6 full CLKs after release.

Source files
------------

// File: rtl/pmod_switch_reader_pkg.sv
// Shared PMOD constants and event FSM state type for the switch reader.
// Optional build macro used by the top: SWITCH_EVENT_OVERFLOW_EN.
package pmod_switch_reader_pkg;

  localparam int PMOD_NUM_PINS      = 8;
  localparam int SW_ACTIVE_LEVEL    = 0;
  localparam int LED_ACTIVE_LEVEL   = 0;
  localparam int DEBOUNCE_1MS_12MHZ = 12000;

  typedef enum logic {
    EV_IDLE    = 1'b0,
    EV_PENDING = 1'b1
  } event_state_e;

endpackage

// File: rtl/pmod_switch_reader_debounce.sv
// One switch bit: 2-flop synchroniser on the raw active-low pin, inversion to
// active-high, and a stability counter that must see DEBOUNCE_CYCLES mismatches in a row.
module pmod_switch_reader_debounce #(
  parameter int DEBOUNCE_CYCLES = 12000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic sw_n,
  output logic stable,
  output logic stable_next
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_n;
  logic             sync2_n;
  logic             synced;
  logic             settle;
  logic [CNT_W-1:0] cnt;

  assign synced      = ~sync2_n;
  assign settle      = (synced != stable) && (cnt == CNT_MAX);
  assign stable_next = settle ? synced : stable;

  // Sync flops reset to the released level so no spurious press is seen.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_n <= 1'b1;
      sync2_n <= 1'b1;
      cnt     <= '0;
      stable  <= 1'b0;
    end else begin
      sync1_n <= sw_n;
      sync2_n <= sync1_n;
      if ((synced == stable) || settle) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      stable <= stable_next;
    end
  end

endmodule

// File: rtl/pmod_switch_reader.sv
// PMOD switch reader: per-bit debounce plus a change-event FSM on valid/ready.
// Define SWITCH_EVENT_OVERFLOW_EN to add the sticky o_event_overflow output.
module pmod_switch_reader
  import pmod_switch_reader_pkg::*;
#(
  parameter int NUM_SW          = PMOD_NUM_PINS,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_12MHZ
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NUM_SW-1:0] SW_N,
  output logic [NUM_SW-1:0] o_switches,
  output logic              o_event_valid,
  input  logic              i_event_ready,
  output logic [NUM_SW-1:0] o_event_data,
  output logic [NUM_SW-1:0] o_event_changed,
`ifdef SWITCH_EVENT_OVERFLOW_EN
  output logic              o_event_overflow,
`else
`endif
  output event_state_e      o_dbg_state
);

  logic [NUM_SW-1:0] stable;
  logic [NUM_SW-1:0] stable_next;
  logic [NUM_SW-1:0] change;
  logic              any_change;
  event_state_e      state;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    pmod_switch_reader_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .sw_n       (SW_N[i]),
      .stable     (stable[i]),
      .stable_next(stable_next[i])
    );
  end

  assign change      = stable_next ^ stable;
  assign any_change  = |change;
  assign o_switches  = stable;
  assign o_dbg_state = state;

  // Handshake: an event transfers on a CLK edge where o_event_valid && i_event_ready.
  // Once valid rises it stays high with data/changed frozen until that transfer,
  // except that new changes merge in (data follows, changed accumulates).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state           <= EV_IDLE;
      o_event_valid   <= 1'b0;
      o_event_data    <= '0;
      o_event_changed <= '0;
`ifdef SWITCH_EVENT_OVERFLOW_EN
      o_event_overflow <= 1'b0;
`else
`endif
    end else begin
      case (state)
        EV_IDLE: begin
          if (any_change) begin
            state           <= EV_PENDING;
            o_event_valid   <= 1'b1;
            o_event_data    <= stable_next;
            o_event_changed <= change;
          end
        end
        EV_PENDING: begin
          if (i_event_ready) begin
`ifdef SWITCH_EVENT_OVERFLOW_EN
            o_event_overflow <= 1'b0;
`else
`endif
            if (any_change) begin
              o_event_data    <= stable_next;
              o_event_changed <= change;
            end else begin
              state           <= EV_IDLE;
              o_event_valid   <= 1'b0;
              o_event_changed <= '0;
            end
          end else if (any_change) begin
            o_event_data    <= stable_next;
            o_event_changed <= o_event_changed | change;
`ifdef SWITCH_EVENT_OVERFLOW_EN
            o_event_overflow <= 1'b1;
`else
`endif
          end
        end
        default: state <= EV_IDLE;
      endcase
    end
  end

endmodule
